// File: rtl/synthesijer_method_arbiter_pkg.sv
// Shared definitions for the Synthesijer method-port arbiter: FSM state
// encoding and the index-width helper used for grant_id and the rotation pointer.
package synthesijer_method_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Bits needed to encode an index in 0..n-1 (never less than one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/synthesijer_method_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// the rotation pointer (wrapping past N-1) wins. No state, so any scheduler
// can reuse it by owning its own pointer.
module rr_arbiter
    import synthesijer_method_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] rot;
    logic [IW:0]  sum;

    // Rotate requests so bit 0 is the pointer position, pick the lowest set
    // bit, then map the offset back to an absolute requester index.
    always_comb begin
        rot = N'({req, req} >> ptr);
        any = 1'b0;
        idx = '0;
        sum = '0;
        for (int off = 0; off < N; off++) begin
            if (!any && rot[off]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IW+1)'(off);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx = sum[IW-1:0];
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/synthesijer_method_arbiter.sv
// Shares one Synthesijer method port (req/busy/return + arguments) among
// NUM_REQ callers. Round-robin grant, argument latch, req/busy handshake,
// one-cycle acknowledge to the winner, and a timeout for hung methods.
module synthesijer_method_arbiter
    import synthesijer_method_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ARG_WIDTH = 32,
    parameter int RET_WIDTH = 32,
    parameter int TIMEOUT   = 10000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             call_req,
    input  logic [NUM_REQ*ARG_WIDTH-1:0]   call_arg,
    output logic [NUM_REQ-1:0]             call_ack,
    output logic [RET_WIDTH-1:0]           call_return,
    output logic                           call_err,
    output logic                           active,
    output logic [idx_width(NUM_REQ)-1:0]  grant_id,
    output logic                           m_req,
    output logic [ARG_WIDTH-1:0]           m_arg,
    input  logic                           m_busy,
    input  logic [RET_WIDTH-1:0]           m_return
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..16");
    end
    if (TIMEOUT < 4) begin : g_bad_timeout
        $error("TIMEOUT must be at least 4");
    end

    state_t                          state_q, state_d;
    logic [IW-1:0]                   ptr_q;
    logic [IW-1:0]                   grant_q;
    logic [ARG_WIDTH-1:0]            arg_q;
    logic [RET_WIDTH-1:0]            ret_q;
    logic                            err_q;
    logic [TW-1:0]                   tmo_q;

    logic [NUM_REQ-1:0]              win_gnt;
    logic [IW-1:0]                   win_idx;
    logic                            win_any;
    logic [NUM_REQ-1:0][ARG_WIDTH-1:0] arg_arr;
    logic [ARG_WIDTH-1:0]            win_arg;

    logic                            grant_load;
    logic                            ret_cap;
    logic                            err_set;
    logic                            tmo_hit;

    assign arg_arr = call_arg;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req (call_req),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // One-hot AND-OR select of the winner's argument slice.
    always_comb begin
        win_arg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                win_arg = win_arg | arg_arr[i];
            end
        end
    end

    // Counter has reached its last allowed cycle; the next edge aborts the call.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes. A completing method wins over a
    // timeout that expires in the same cycle.
    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        ret_cap    = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d    = ST_ISSUE;
                    grant_load = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (tmo_hit) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end else if (m_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!m_busy) begin
                    state_d = ST_DONE;
                    ret_cap = 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant/argument latch, return capture, error flag, timeout counter and
    // rotation pointer. The pointer only advances on a completed ack, so a
    // reset mid-call leaves no trace of the aborted grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            grant_q <= '0;
            arg_q   <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            if (grant_load) begin
                grant_q <= win_idx;
                arg_q   <= win_arg;
                err_q   <= 1'b0;
                tmo_q   <= '0;
            end else if (state_q == ST_ISSUE || state_q == ST_WAIT_DONE) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (ret_cap) begin
                ret_q <= m_return;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_DONE) begin
                ptr_q <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    assign m_req       = (state_q == ST_ISSUE);
    assign active      = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);
    assign call_ack    = (state_q == ST_DONE) ? (NUM_REQ'(1) << grant_q) : '0;
    assign call_err    = (state_q == ST_DONE) && err_q;
    assign call_return = ret_q;
    assign grant_id    = grant_q;
    assign m_arg       = arg_q;

endmodule

// File: tb/tb_synthesijer_method_arbiter.sv
// Bench for synthesijer_method_arbiter: directed calls against a behavioural
// Synthesijer method model, with an ack scoreboard fed by the stimulus.
module tb_synthesijer_method_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ARG_WIDTH = 32;
    localparam int RET_WIDTH = 32;
    localparam int TIMEOUT   = 50;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [NUM_REQ-1:0]           call_req;
    logic [NUM_REQ*ARG_WIDTH-1:0] call_arg;
    logic [NUM_REQ-1:0]           call_ack;
    logic [RET_WIDTH-1:0]         call_return;
    logic                         call_err;
    logic                         active;
    logic [1:0]                   grant_id;
    logic                         m_req;
    logic [ARG_WIDTH-1:0]         m_arg;
    logic                         m_busy;
    logic [RET_WIDTH-1:0]         m_return;

    typedef struct {
        int          id;
        logic [31:0] ret;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   acks[NUM_REQ];

    // method model knobs
    int          busy_len  = 3;
    bit          hang      = 1'b0;
    bit          fixed_en  = 1'b0;
    logic [31:0] fixed_ret = '0;
    logic [31:0] ret_pending;
    int          left;

    always #5 clk = ~clk;

    synthesijer_method_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ARG_WIDTH (ARG_WIDTH),
        .RET_WIDTH (RET_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .call_req    (call_req),
        .call_arg    (call_arg),
        .call_ack    (call_ack),
        .call_return (call_return),
        .call_err    (call_err),
        .active      (active),
        .grant_id    (grant_id),
        .m_req       (m_req),
        .m_arg       (m_arg),
        .m_busy      (m_busy),
        .m_return    (m_return)
    );

    function automatic exp_t mk(input int id, input logic [31:0] ret, input logic err);
        exp_t e;
        e.id  = id;
        e.ret = ret;
        e.err = err;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_active(input string name);
        int n = 0;
        while (active !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_active"}, 64'(active), 64'd1);
    endtask

    // Requesters hold call_req until acked, then drop it in the ack cycle.
    task automatic serve(input int n, input string name);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (|call_ack === 1'b1) begin
                call_req = call_req & ~call_ack;
                got++;
            end
        end
        check({name, "_ack_count"}, 64'(got), 64'(n));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_m_req"},       64'(m_req),       64'd0);
        check({name, "_m_arg"},       64'(m_arg),       64'd0);
        check({name, "_call_ack"},    64'(call_ack),    64'd0);
        check({name, "_call_return"}, 64'(call_return), 64'd0);
        check({name, "_call_err"},    64'(call_err),    64'd0);
        check({name, "_active"},      64'(active),      64'd0);
        check({name, "_grant_id"},    64'(grant_id),    64'd0);
    endtask

    // Behavioural generated method: busy rises the cycle after req is seen,
    // stays up busy_len cycles (forever while hang), then presents the result.
    initial begin
        m_busy      = 1'b0;
        m_return    = '0;
        ret_pending = '0;
        left        = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_busy = 1'b0;
                left   = 0;
            end else if (m_busy) begin
                if (!hang) begin
                    if (left <= 0) begin
                        m_busy   = 1'b0;
                        m_return = ret_pending;
                    end else begin
                        left--;
                    end
                end
            end else if (m_req) begin
                m_busy      = 1'b1;
                left        = busy_len - 1;
                ret_pending = fixed_en ? fixed_ret : (m_arg << 1);
            end
        end
    end

    // Scoreboard monitor: every ack must match the oldest expected response.
    initial begin
        for (int i = 0; i < NUM_REQ; i++) acks[i] = 0;
        forever begin
            @(negedge clk);
            if (|call_ack === 1'b1) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (call_ack[i]) acks[i]++;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack 0x%0h, expected none", call_ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_vector", 64'(call_ack),    64'(NUM_REQ'(1) << mon_e.id));
                    check("ack_return", 64'(call_return), 64'(mon_e.ret));
                    check("ack_err",    64'(call_err),    64'(mon_e.err));
                    check("ack_m_req",  64'(m_req),       64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1, a2, lat, cnt;
        reset    = 1'b1;
        call_req = '0;
        call_arg = '0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // contention: all four at once, arg = index, served 0,1,2,3
        busy_len = 3;
        for (int i = 0; i < NUM_REQ; i++) call_arg[i*ARG_WIDTH +: ARG_WIDTH] = 32'(i);
        exp_q.push_back(mk(0, 32'h0, 1'b0));
        exp_q.push_back(mk(1, 32'h2, 1'b0));
        exp_q.push_back(mk(2, 32'h4, 1'b0));
        exp_q.push_back(mk(3, 32'h6, 1'b0));
        call_req = 4'b1111;
        serve(4, "contention");
        tick(2);

        // next round with only 0 and 3: pointer wrapped to 0, so 0 then 3
        exp_q.push_back(mk(0, 32'h0, 1'b0));
        exp_q.push_back(mk(3, 32'h6, 1'b0));
        call_req = 4'b1001;
        serve(2, "round2");
        tick(2);

        // single call from requester 2, busy for 10 cycles
        busy_len = 10;
        a2 = acks[2];
        call_arg[2*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0005;
        exp_q.push_back(mk(2, 32'h0000_000A, 1'b0));
        call_req[2] = 1'b1;
        wait_active("single");
        check("single_m_req",    64'(m_req),    64'd1);
        check("single_m_arg",    64'(m_arg),    64'h5);
        check("single_grant_id", 64'(grant_id), 64'd2);
        serve(1, "single");
        tick(5);
        check("single_one_pulse", 64'(acks[2] - a2), 64'd1);

        // generated target (Test002 test method): returns 1, minimum latency
        busy_len  = 1;
        fixed_en  = 1'b1;
        fixed_ret = 32'h1;
        call_arg[1*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0011;
        exp_q.push_back(mk(1, 32'h1, 1'b0));
        call_req[1] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(|call_ack === 1'b1) && lat < 100);
        call_req = call_req & ~call_ack;
        check("t002_latency", 64'(lat), 64'd3);
        fixed_en = 1'b0;
        tick(3);

        // timeout: method hangs; ack with err after TIMEOUT cycles, return kept
        busy_len = 3;
        hang     = 1'b1;
        call_arg[0*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0033;
        exp_q.push_back(mk(0, 32'h1, 1'b1));
        call_req[0] = 1'b1;
        wait_active("timeout");
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(|call_ack === 1'b1) && cnt < 200);
        call_req = call_req & ~call_ack;
        check("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
        hang = 1'b0;
        tick(10);

        // next requester after the timeout is served normally
        call_arg[1*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0007;
        exp_q.push_back(mk(1, 32'h0000_000E, 1'b0));
        call_req[1] = 1'b1;
        serve(1, "post_timeout");
        tick(2);

        // withdrawal: 1 requests and drops during 3's call; 3 drops after grant
        busy_len = 10;
        a1 = acks[1];
        call_arg[3*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0003;
        call_arg[1*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0009;
        exp_q.push_back(mk(3, 32'h6, 1'b0));
        call_req[3] = 1'b1;
        wait_active("withdraw");
        check("withdraw_grant_id", 64'(grant_id), 64'd3);
        call_req[1] = 1'b1;
        tick(2);
        call_req[1] = 1'b0;
        call_req[3] = 1'b0;
        serve(1, "withdraw");
        tick(20);
        check("withdraw_req1_never_acked", 64'(acks[1] - a1), 64'd0);

        // move the rotation pointer off zero before the reset test
        busy_len = 3;
        call_arg[1*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0002;
        exp_q.push_back(mk(1, 32'h4, 1'b0));
        call_req[1] = 1'b1;
        serve(1, "pre_reset");
        tick(2);

        // reset in WAIT_DONE: no ack, all outputs zero
        busy_len = 20;
        call_arg[2*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0004;
        call_req[2] = 1'b1;
        wait_active("midcall");
        tick(3);
        check("midcall_in_wait", 64'({active, m_req}), 64'b10);
        reset    = 1'b1;
        call_req = '0;
        tick(1);
        check_all_zero("midcall_reset");
        tick(1);
        reset = 1'b0;
        tick(3);

        // after reset, 0 and 2 both request: pointer is back at 0
        busy_len = 3;
        call_arg[0*ARG_WIDTH +: ARG_WIDTH] = 32'h0000_0001;
        exp_q.push_back(mk(0, 32'h2, 1'b0));
        exp_q.push_back(mk(2, 32'h8, 1'b0));
        call_req = 4'b0101;
        serve(2, "post_reset");
        tick(5);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
